// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for the two-stage pipelined ALU.
// slave = the ALU itself, master = whoever issues ops and consumes results.
interface alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       select;
   logic             mode;
   logic             carry_in;
   logic             cin_sel;
   logic             flag_we;
   logic             clear_flags;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   logic             negative;
   logic             equal;
   logic             illegal;
   logic [3:0]       flags;

   modport slave (
      input  in_valid, in_a, in_b, select, mode, carry_in, cin_sel, flag_we,
             clear_flags, out_ready,
      output in_ready, out_valid, alu_out, carry_out, overflow, zero,
             negative, equal, illegal, flags
   );

   modport master (
      output in_valid, in_a, in_b, select, mode, carry_in, cin_sel, flag_we,
             clear_flags, out_ready,
      input  in_ready, out_valid, alu_out, carry_out, overflow, zero,
             negative, equal, illegal, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers the accepted op, S2 computes and
// registers the result together with per-result flags. A persistent
// {C,Z,N,V} register can feed its carry back for multi-word arithmetic.
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   alu_pipe_if.slave bus
);

   // Two-input logic function selected by s, evaluated for one bit.
   function automatic logic logic_bit(input logic [3:0] s, input logic a, input logic b);
      case (s)
         4'h0: logic_bit = ~a;
         4'h1: logic_bit = ~(a | b);
         4'h2: logic_bit = ~a & b;
         4'h3: logic_bit = 1'b0;
         4'h4: logic_bit = ~(a & b);
         4'h5: logic_bit = ~b;
         4'h6: logic_bit = a ^ b;
         4'h7: logic_bit = a & ~b;
         4'h8: logic_bit = ~a | b;
         4'h9: logic_bit = ~(a ^ b);
         4'hA: logic_bit = b;
         4'hB: logic_bit = a & b;
         4'hC: logic_bit = 1'b1;
         4'hD: logic_bit = a | ~b;
         4'hE: logic_bit = a | b;
         default: logic_bit = a;
      endcase
   endfunction

   // Stage 1 registers
   logic             s1_v_reg;
   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;
   logic [3:0]       s1_sel_reg;
   logic             s1_mode_reg;
   logic             s1_cin_reg;
   logic             s1_csel_reg;
   logic             s1_fwe_reg;

   // Stage 2 (output) registers
   logic             s2_v_reg;
   logic [WIDTH-1:0] out_reg;
   logic             c_reg, v_reg, z_reg, n_reg, eq_reg, ill_reg;
   logic [3:0]       flags_reg;

   logic adv2, in_ready_w, accept;

   assign adv2       = !s2_v_reg | bus.out_ready;
   assign in_ready_w = !s1_v_reg | adv2;
   assign accept     = bus.in_valid & in_ready_w;

   // Bitwise logic unit
   logic [WIDTH-1:0] logic_res;
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
         assign logic_res[gi] = logic_bit(s1_sel_reg, s1_a_reg[gi], s1_b_reg[gi]);
      end
   endgenerate

   // Adder operand selection; carry may come from the persistent C flag
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_c, chain_c;
   logic [WIDTH:0]   sum;

   assign chain_c = s1_csel_reg ? flags_reg[3] : s1_cin_reg;

   // Map arithmetic select onto the operands fed to a single adder
   always_comb begin
      add_x = s1_a_reg;
      add_y = '0;
      add_c = 1'b0;
      case (s1_sel_reg[2:0])
         3'd0: begin add_y = s1_b_reg;  add_c = chain_c; end
         3'd1: begin add_y = ~s1_b_reg; add_c = chain_c; end
         3'd2: begin add_c = 1'b1; end
         3'd3: begin add_y = '1; end
         3'd4: begin add_y = s1_a_reg;  add_c = chain_c; end
         3'd5: begin add_x = ~s1_a_reg; add_c = 1'b1; end
         3'd6: begin end
         default: begin add_y = ~s1_b_reg; add_c = 1'b1; end
      endcase
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

   // Result mux and per-result flags
   logic [WIDTH-1:0] res_next;
   logic             c_next, v_next, z_next, n_next, eq_next, ill_next;
   logic [3:0]       flags_next;

   // Pick logic or arithmetic result and form the flag-register update value
   always_comb begin
      res_next = '0;
      c_next   = 1'b0;
      v_next   = 1'b0;
      ill_next = 1'b0;
      if (s1_mode_reg) begin
         res_next = logic_res;
      end else if (s1_sel_reg[3]) begin
         ill_next = 1'b1;
      end else begin
         res_next = sum[WIDTH-1:0];
         c_next   = sum[WIDTH];
         v_next   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                    (sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      z_next  = (res_next == '0);
      n_next  = res_next[WIDTH-1];
      eq_next = (s1_a_reg == s1_b_reg);
      // Logic ops keep the stored carry and clear V
      if (s1_mode_reg) flags_next = {flags_reg[3], z_next, n_next, 1'b0};
      else             flags_next = {c_next, z_next, n_next, v_next};
   end

   // Stage 1: capture accepted op, hold while S2 is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_reg    <= 1'b0;
         s1_a_reg    <= '0;
         s1_b_reg    <= '0;
         s1_sel_reg  <= '0;
         s1_mode_reg <= 1'b0;
         s1_cin_reg  <= 1'b0;
         s1_csel_reg <= 1'b0;
         s1_fwe_reg  <= 1'b0;
      end else begin
         s1_v_reg <= accept | (s1_v_reg & !adv2);
         if (accept) begin
            s1_a_reg    <= bus.in_a;
            s1_b_reg    <= bus.in_b;
            s1_sel_reg  <= bus.select;
            s1_mode_reg <= bus.mode;
            s1_cin_reg  <= bus.carry_in;
            s1_csel_reg <= bus.cin_sel;
            s1_fwe_reg  <= bus.flag_we;
         end
      end
   end

   // Stage 2: register result; outputs only change when the stage advances
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v_reg <= 1'b0;
         out_reg  <= '0;
         c_reg    <= 1'b0;
         v_reg    <= 1'b0;
         z_reg    <= 1'b0;
         n_reg    <= 1'b0;
         eq_reg   <= 1'b0;
         ill_reg  <= 1'b0;
      end else if (adv2) begin
         s2_v_reg <= s1_v_reg;
         if (s1_v_reg) begin
            out_reg <= res_next;
            c_reg   <= c_next;
            v_reg   <= v_next;
            z_reg   <= z_next;
            n_reg   <= n_next;
            eq_reg  <= eq_next;
            ill_reg <= ill_next;
         end
      end
   end

   // Persistent flags: clear has priority over an op's write-back
   always_ff @(posedge clk) begin
      if (rst || bus.clear_flags)
         flags_reg <= '0;
      else if (s1_v_reg && adv2 && s1_fwe_reg && !ill_next)
         flags_reg <= flags_next;
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = s2_v_reg;
   assign bus.alu_out   = out_reg;
   assign bus.carry_out = c_reg;
   assign bus.overflow  = v_reg;
   assign bus.zero      = z_reg;
   assign bus.negative  = n_reg;
   assign bus.equal     = eq_reg;
   assign bus.illegal   = ill_reg;
   assign bus.flags     = flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: table of single ops plus hand-written
// sequences for chaining, stalls, flag clearing and reset mid-operation.
module tb_alu_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(16)) bus ();
   alu_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [15:0] a, b;
      logic [3:0]  sel;
      logic        mode, cin, csel, fwe;
      logic [15:0] e_out;
      logic        e_c, e_v, e_z, e_n, e_eq, e_ill;
      logic [3:0]  e_flags;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];
   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [3:0] sel,
                               logic mode, logic cin, logic csel, logic fwe,
                               logic [15:0] eo, logic ec, logic ev, logic ez,
                               logic en, logic eeq, logic eill, logic [3:0] ef);
      vec_t v;
      v.a = a; v.b = b; v.sel = sel; v.mode = mode; v.cin = cin; v.csel = csel;
      v.fwe = fwe; v.e_out = eo; v.e_c = ec; v.e_v = ev; v.e_z = ez; v.e_n = en;
      v.e_eq = eeq; v.e_ill = eill; v.e_flags = ef;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                        input logic mode, input logic cin, input logic csel, input logic fwe);
      bus.in_valid = 1'b1;
      bus.in_a = a; bus.in_b = b; bus.select = sel; bus.mode = mode;
      bus.carry_in = cin; bus.cin_sel = csel; bus.flag_we = fwe;
   endtask

   initial begin
      bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.select = 0; bus.mode = 0;
      bus.carry_in = 0; bus.cin_sel = 0; bus.flag_we = 0; bus.clear_flags = 0;
      bus.out_ready = 1;

      //         a        b        sel  m  ci cs we  out      c  v  z  n  eq il flags
      vecs[0]  = mk(16'hFFFF, 16'h0001, 4'h0, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 0, 0, 4'b1100);
      vecs[1]  = mk(16'h0001, 16'h0002, 4'h0, 0, 0, 1, 1, 16'h0004, 0, 0, 0, 0, 0, 0, 4'b0000);
      vecs[2]  = mk(16'h8000, 16'h0001, 4'h1, 0, 1, 0, 1, 16'h7FFF, 1, 1, 0, 0, 0, 0, 4'b1001);
      vecs[3]  = mk(16'h00FF, 16'h0F0F, 4'h6, 1, 0, 0, 1, 16'h0FF0, 0, 0, 0, 0, 0, 0, 4'b1000);
      vecs[4]  = mk(16'h1234, 16'h1234, 4'hA, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 1, 4'b1000);
      vecs[5]  = mk(16'h7FFF, 16'h0000, 4'h2, 0, 0, 0, 0, 16'h8000, 0, 1, 0, 1, 0, 0, 4'b1000);
      vecs[6]  = mk(16'h0000, 16'h0000, 4'h3, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 1, 1, 0, 4'b0010);
      vecs[7]  = mk(16'h0001, 16'h0000, 4'h5, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 4'b0010);
      vecs[8]  = mk(16'h8000, 16'h0000, 4'h4, 0, 1, 0, 1, 16'h0001, 1, 1, 0, 0, 0, 0, 4'b1001);
      vecs[9]  = mk(16'h0005, 16'h0005, 4'h7, 0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 0, 4'b1100);
      vecs[10] = mk(16'hABCD, 16'h1111, 4'h6, 0, 0, 0, 1, 16'hABCD, 0, 0, 0, 1, 0, 0, 4'b0010);
      vecs[11] = mk(16'h5555, 16'hAAAA, 4'h3, 1, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0100);
      vecs[12] = mk(16'hF0F0, 16'h0000, 4'h0, 1, 0, 0, 0, 16'h0F0F, 0, 0, 0, 0, 0, 0, 4'b0100);
      vecs[13] = mk(16'h0000, 16'hFFFF, 4'hD, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0100);
      vecs[14] = mk(16'h0005, 16'h0003, 4'h1, 0, 1, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 4'b1000);
      vecs[15] = mk(16'hFFFF, 16'h8001, 4'hB, 1, 0, 0, 1, 16'h8001, 0, 0, 0, 1, 0, 0, 4'b1010);
      vecs[16] = mk(16'h7FFF, 16'h0001, 4'h0, 0, 0, 0, 1, 16'h8000, 0, 1, 0, 1, 0, 0, 4'b0011);
      vecs[17] = mk(16'h8000, 16'h0000, 4'hF, 1, 0, 0, 1, 16'h8000, 0, 0, 0, 1, 0, 0, 4'b0010);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_alu_out", bus.alu_out, 0);
      chk("rst_flags", bus.flags, 0);
      chk("rst_carry", bus.carry_out, 0);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);

      // Table-driven single ops; flags accumulate from one vector to the next
      for (int i = 0; i < NV; i++) begin
         bit found;
         drive(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].mode, vecs[i].cin,
               vecs[i].csel, vecs[i].fwe);
         @(negedge clk);
         bus.in_valid = 1'b0;
         found = 0;
         for (int t = 0; t < 10 && !found; t++) begin
            if (bus.out_valid) found = 1;
            else @(negedge clk);
         end
         if (!found) begin
            checks++; errors++;
            $display("FAIL vec%0d_timeout actual=no_out_valid expected=out_valid", i);
         end else begin
            chk($sformatf("vec%0d_out", i), bus.alu_out, vecs[i].e_out);
            chk($sformatf("vec%0d_carry", i), bus.carry_out, vecs[i].e_c);
            chk($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].e_v);
            chk($sformatf("vec%0d_zero", i), bus.zero, vecs[i].e_z);
            chk($sformatf("vec%0d_neg", i), bus.negative, vecs[i].e_n);
            chk($sformatf("vec%0d_equal", i), bus.equal, vecs[i].e_eq);
            chk($sformatf("vec%0d_illegal", i), bus.illegal, vecs[i].e_ill);
            chk($sformatf("vec%0d_flags", i), bus.flags, vecs[i].e_flags);
            $display("vec%0d a=%h b=%h sel=%h mode=%0d -> out=%h flags=%b",
                     i, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].mode,
                     bus.alu_out, bus.flags);
         end
      end

      // Standalone clear_flags pulse (flags are 0010 here)
      bus.clear_flags = 1'b1;
      @(negedge clk) bus.clear_flags = 1'b0;
      chk("clear_pulse_flags", bus.flags, 0);
      $display("clear_flags pulse -> flags=%b", bus.flags);

      // clear_flags coinciding with an op's flag write: clear wins
      drive(16'hFFFF, 16'h0001, 4'h0, 0, 0, 0, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.clear_flags = 1'b1;
      @(negedge clk);
      bus.clear_flags = 1'b0;
      chk("clrwin_valid", bus.out_valid, 1);
      chk("clrwin_carry", bus.carry_out, 1);
      chk("clrwin_flags", bus.flags, 0);
      $display("clear vs write -> out=%h flags=%b", bus.alu_out, bus.flags);

      // Back-to-back 32-bit add: high word chains carry from flag C
      drive(16'hFFFF, 16'h0001, 4'h0, 0, 0, 0, 1);
      @(negedge clk);
      drive(16'h0001, 16'h0002, 4'h0, 0, 0, 1, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("chain_lo_out", bus.alu_out, 16'h0000);
      chk("chain_lo_carry", bus.carry_out, 1);
      $display("chain low -> out=%h c=%0d", bus.alu_out, bus.carry_out);
      @(negedge clk);
      chk("chain_hi_valid", bus.out_valid, 1);
      chk("chain_hi_out", bus.alu_out, 16'h0004);
      chk("chain_hi_flags", bus.flags, 4'b0000);
      $display("chain high -> out=%h flags=%b", bus.alu_out, bus.flags);
      @(negedge clk);

      // Stall: out_ready low for 5 cycles with 3 ops issued
      bus.out_ready = 1'b0;
      drive(16'h0001, 16'h0001, 4'h0, 0, 0, 0, 0);
      @(negedge clk);
      chk("stall_ready0", bus.in_ready, 1);
      drive(16'h0002, 16'h0002, 4'h0, 0, 0, 0, 0);
      @(negedge clk);
      drive(16'h0003, 16'h0003, 4'h0, 0, 0, 0, 0);
      chk("stall_ready_drop", bus.in_ready, 0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_out", bus.alu_out, 16'h0002);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d_out", k), bus.alu_out, 16'h0002);
         chk($sformatf("stall_hold%0d_valid", k), bus.out_valid, 1);
         chk($sformatf("stall_hold%0d_ready", k), bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("stall_release_ready", bus.in_ready, 1);
      $display("stall released -> first result out=%h", bus.alu_out);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("stall_r1_valid", bus.out_valid, 1);
      chk("stall_r1_out", bus.alu_out, 16'h0004);
      $display("stall result 2 -> out=%h", bus.alu_out);
      @(negedge clk);
      chk("stall_r2_valid", bus.out_valid, 1);
      chk("stall_r2_out", bus.alu_out, 16'h0006);
      $display("stall result 3 -> out=%h", bus.alu_out);
      @(negedge clk);
      chk("stall_drain", bus.out_valid, 0);

      // Reset with both stages full
      bus.out_ready = 1'b0;
      drive(16'hFFFF, 16'h0001, 4'h0, 0, 0, 0, 1);
      @(negedge clk);
      drive(16'h0005, 16'h0006, 4'h0, 0, 0, 0, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("midrst_pre_valid", bus.out_valid, 1);
      chk("midrst_pre_flags", bus.flags, 4'b1100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_flags", bus.flags, 0);
      chk("midrst_out", bus.alu_out, 0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_nostale%0d", k), bus.out_valid, 0);
      end
      $display("reset mid-op -> out_valid=%0d flags=%b", bus.out_valid, bus.flags);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
